// File: rtl/cb_spi_stream_slave_if.sv
// cb_spi_stream_slave_if: SPI pins plus tx/rx word streams; slave = responder side, master = controller/DMA side
interface cb_spi_stream_slave_if;
  logic        sclk_i;
  logic        mosi_i;
  logic        cs_b_i;
  logic        miso_o;
  logic        miso_oe_o;
  logic [31:0] tx_tdata_i;
  logic        tx_tvalid_i;
  logic        tx_tready_o;
  logic [31:0] rx_tdata_o;
  logic        rx_tvalid_o;
  logic        frame_active_o;
  logic [15:0] word_count_o;
  logic        underflow_o;
  logic        abort_o;
  modport slave (
    input  sclk_i, mosi_i, cs_b_i, tx_tdata_i, tx_tvalid_i,
    output miso_o, miso_oe_o, tx_tready_o, rx_tdata_o, rx_tvalid_o,
    output frame_active_o, word_count_o, underflow_o, abort_o
  );
  modport master (
    output sclk_i, mosi_i, cs_b_i, tx_tdata_i, tx_tvalid_i,
    input  miso_o, miso_oe_o, tx_tready_o, rx_tdata_o, rx_tvalid_o,
    input  frame_active_o, word_count_o, underflow_o, abort_o
  );
endinterface

// File: rtl/cb_spi_stream_slave.sv
// cb_spi_stream_slave: mode-0 SPI responder streaming 32-bit tx words out on miso and collecting mosi words (clk_i, rst_b_i, bus: SPI pins + tx/rx streams)
module cb_spi_stream_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_WORD   = 32'hFFFF_FFFF
) (
  input logic                   clk_i,
  input logic                   rst_b_i,
  cb_spi_stream_slave_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
  logic        sclk_s, mosi_s, cs_s, sclk_d, cs_d;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        shifting, load;
  logic [31:0] tx_sh, rx_sh, rx_data;
  logic [4:0]  bitcnt;
  logic        rx_valid;
  logic [15:0] word_count;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi_i};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.cs_b_i};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) state <= IDLE;
    else          state <= state_nx;
  end
  always_comb begin
    state_nx = cs_rise ? IDLE :
               state == IDLE ? (cs_fall ? LOAD : IDLE) :
               state == LOAD ? SHIFT : state;
  end
  // CS rise suppresses any sclk edge seen in the same cycle, so a final
  // falling edge that coincides with CS release never pulls another word.
  always_comb begin
    shifting           = (state == SHIFT) & ~cs_rise;
    load               = ~cs_rise & ((state == LOAD) | (state == SHIFT & sclk_fall & bitcnt == 5'd0));
    bus.tx_tready_o    = load & bus.tx_tvalid_i;
    bus.underflow_o    = load & ~bus.tx_tvalid_i;
    bus.abort_o        = cs_rise & (state != IDLE) & (bitcnt != 5'd0);
    bus.miso_o         = (state == SHIFT) & tx_sh[31];
    bus.miso_oe_o      = state != IDLE;
    bus.frame_active_o = ~cs_s;
    bus.rx_tdata_o     = rx_data;
    bus.rx_tvalid_o    = rx_valid;
    bus.word_count_o   = word_count;
  end
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      bitcnt     <= '0;
      word_count <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) bitcnt <= '0;
      if (state == IDLE && cs_fall) word_count <= '0;
      if (load) tx_sh <= bus.tx_tvalid_i ? bus.tx_tdata_i : IDLE_WORD;
      else if (shifting && sclk_fall) tx_sh <= {tx_sh[30:0], 1'b0};
      if (shifting && sclk_rise) begin
        rx_sh  <= {rx_sh[30:0], mosi_s};
        bitcnt <= bitcnt + 5'd1;
        if (&bitcnt) begin
          rx_data  <= {rx_sh[30:0], mosi_s};
          rx_valid <= 1'b1;
          if (~&word_count) word_count <= word_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cb_spi_stream_slave.sv
// tb_cb_spi_stream_slave: randomized SPI master + DMA producer against a word-level reference model
module tb_cb_spi_stream_slave;
  localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;
  cb_spi_stream_slave_if bus();
  cb_spi_stream_slave dut (.clk_i(clk), .rst_b_i(rst_b), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] src_q[$];
  logic [31:0] model_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] mosi_w[8];
  logic [31:0] miso_w[8];
  int n_rdy, n_unf, n_abt;
  bit rdy_seen = 1'b0;
  logic oe_mid;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    rdy_seen = bus.tx_tready_o;
    if (bus.tx_tready_o) n_rdy++;
    if (bus.underflow_o) n_unf++;
    if (bus.abort_o) n_abt++;
    if (bus.rx_tvalid_o) rx_q.push_back(bus.rx_tdata_o);
  end
  always @(posedge clk) begin
    #1;
    if (rdy_seen && src_q.size() > 0) src_q.delete(0);
    bus.tx_tvalid_i = src_q.size() != 0;
    bus.tx_tdata_i  = src_q.size() != 0 ? src_q[0] : 32'h0;
  end
  task automatic push_word(input logic [31:0] w);
    src_q.push_back(w);
    model_q.push_back(w);
  endtask
  task automatic clear_stats();
    n_rdy = 0;
    n_unf = 0;
    n_abt = 0;
    rx_q.delete();
    miso_w = '{default: 32'h0};
  endtask
  task automatic frame(input int n, input int rst_at);
    bus.cs_b_i = 1'b0;
    #100;
    for (int i = 0; i < n; i++) begin
      bus.mosi_i = mosi_w[i/32][31 - i%32];
      #50;
      if (i == rst_at) begin
        rst_b = 1'b0;
        bus.cs_b_i = 1'b1;
        #30;
        rst_b = 1'b1;
        #100;
        return;
      end
      miso_w[i/32][31 - i%32] = bus.miso_o;
      if (i == 0) oe_mid = bus.miso_oe_o;
      bus.sclk_i = 1'b1;
      #50;
      bus.sclk_i = 1'b0;
      if (i == n - 1) bus.cs_b_i = 1'b1;
    end
    #200;
  endtask
  task automatic run_frame(input int n);
    int nw, e_rdy, e_unf, bits;
    logic [31:0] w, mask;
    clear_stats();
    frame(n, -1);
    nw = (n + 31) / 32;
    e_rdy = 0;
    e_unf = 0;
    for (int k = 0; k < nw; k++) begin
      if (model_q.size() > 0) begin
        w = model_q.pop_front();
        e_rdy++;
      end else begin
        w = IDLE_WORD;
        e_unf++;
      end
      bits = (n - 32*k) >= 32 ? 32 : n - 32*k;
      mask = ~(32'hFFFF_FFFF >> bits);
      check("miso_word", miso_w[k] & mask, w & mask);
    end
    check("tready_pulses", n_rdy, e_rdy);
    check("underflow_pulses", n_unf, e_unf);
    check("abort_pulses", n_abt, (n % 32) != 0 ? 1 : 0);
    check("rx_count", rx_q.size(), n / 32);
    for (int k = 0; k < n / 32 && k < rx_q.size(); k++) check("rx_word", rx_q[k], mosi_w[k]);
    check("word_count", {16'h0, bus.word_count_o}, n / 32);
    check("oe_in_frame", {31'h0, oe_mid}, 1);
    check("oe_after", {31'h0, bus.miso_oe_o}, 0);
    check("active_after", {31'h0, bus.frame_active_o}, 0);
  endtask
  task automatic rand_mosi();
    for (int k = 0; k < 8; k++) mosi_w[k] = $urandom;
  endtask
  initial begin
    bus.sclk_i = 1'b0;
    bus.mosi_i = 1'b0;
    bus.cs_b_i = 1'b1;
    bus.tx_tdata_i = 32'h0;
    bus.tx_tvalid_i = 1'b0;
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      #20 bus.sclk_i = ~bus.sclk_i;
      bus.cs_b_i = ~bus.cs_b_i;
    end
    check("rst_miso", {31'h0, bus.miso_o}, 0);
    check("rst_tready", {31'h0, bus.tx_tready_o}, 0);
    check("rst_rx_tvalid", {31'h0, bus.rx_tvalid_o}, 0);
    check("rst_word_count", {16'h0, bus.word_count_o}, 0);
    bus.sclk_i = 1'b0;
    bus.cs_b_i = 1'b1;
    #40 rst_b = 1'b1;
    #100;
    push_word(32'hA5C3_0F81);
    mosi_w[0] = 32'h1234_5678;
    run_frame(32);
    check("single_rx", rx_q.size() > 0 ? rx_q[0] : 32'hx, 32'h1234_5678);
    for (int k = 1; k <= 4; k++) push_word(k);
    rand_mosi();
    run_frame(128);
    rand_mosi();
    run_frame(32);
    push_word(32'hDEAD_BEEF);
    push_word(32'hCAFE_F00D);
    rand_mosi();
    run_frame(13);
    rand_mosi();
    run_frame(32);
    push_word(32'h1357_9BDF);
    rand_mosi();
    clear_stats();
    frame(32, 20);
    void'(model_q.pop_front());
    check("rstmid_rx", rx_q.size(), 0);
    check("rstmid_count", {16'h0, bus.word_count_o}, 0);
    check("rstmid_oe", {31'h0, bus.miso_oe_o}, 0);
    push_word(32'h2468_ACE0);
    rand_mosi();
    run_frame(32);
    for (int t = 0; t < 10; t++) begin
      int np;
      np = $urandom_range(0, 4);
      for (int j = 0; j < np; j++) push_word($urandom);
      rand_mosi();
      run_frame($urandom_range(1, 130));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
